sim_host_if: RTL and testbench

- Memory-mapped simulation host device on the CPU data bus; the CPU-side counterpart of the top-level testbench.
- Captures compliance-test signature stores and the test-end write to the tohost word.
- Enforces a cycle watchdog that replaces fixed-time bench termination.
- After the test ends, streams the captured signature out over a valid/ready port and raises done/pass/fail flags for the bench to act on.

---
 rtl/sim_host_if_pkg.sv | 28 ++
 rtl/sim_host_if_sig_buf.sv | 50 +++++
 rtl/sim_host_if.sv | 196 +++++++++++++++++++
 tb/tb_sim_host_if.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_host_if_pkg.sv
// sim_host_if_pkg
//   Shared definitions for the simulation host device: FSM state encoding,
//   default tohost / signature addresses (shared with the dmem decoder) and
//   a byte-enable merge helper used by both the buffer and tohost register.
package sim_host_if_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
    localparam logic [31:0] DEF_SIG_BASE    = 32'h0000_2000;

    // Replace the bytes of old_w selected by strb with those of new_w.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sim_host_if_sig_buf.sv
// sim_host_if_sig_buf
//   SIG_WORDS x 32 signature RAM.
//   Ports:
//     i_clk, i_rst_n           clock, async active-low reset (read register only)
//     i_we/i_waddr/i_wdata/i_wstrb  byte-enabled synchronous write
//     i_raddr_a -> o_rdata_a   combinational read (bus loads)
//     i_re_b/i_raddr_b -> o_rdata_b  registered read (signature dump)
//   The RAM contents are not cleared by reset.
module sim_host_if_sig_buf
    import sim_host_if_pkg::*;
#(
    parameter int unsigned SIG_WORDS = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_we,
    input  logic [$clog2(SIG_WORDS)-1:0] i_waddr,
    input  logic [31:0]                  i_wdata,
    input  logic [3:0]                   i_wstrb,
    input  logic [$clog2(SIG_WORDS)-1:0] i_raddr_a,
    output logic [31:0]                  o_rdata_a,
    input  logic                         i_re_b,
    input  logic [$clog2(SIG_WORDS)-1:0] i_raddr_b,
    output logic [31:0]                  o_rdata_b
);

    logic [31:0] r_mem [SIG_WORDS];
    logic [31:0] r_rdata_b;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= apply_wstrb(r_mem[i_waddr], i_wdata, i_wstrb);
    end

    // Write-first bypass: a watchdog expiry can start the dump in the same
    // cycle as a store to word 0, and the prefetch must see that store.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata_b <= '0;
        end else if (i_re_b) begin
            if (i_we && (i_waddr == i_raddr_b))
                r_rdata_b <= apply_wstrb(r_mem[i_raddr_b], i_wdata, i_wstrb);
            else
                r_rdata_b <= r_mem[i_raddr_b];
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/sim_host_if.sv
// sim_host_if
//   Memory-mapped simulation host on the CPU data bus. Captures signature
//   stores and the tohost end-of-test write, runs a cycle watchdog, then
//   streams the captured signature over a valid/ready port and reports
//   done/pass/timeout/fail_code.
//   Ports:
//     i_clk, i_rst_n                      clock, async active-low reset
//     i_bus_we/re/addr/wdata/wstrb        CPU data bus strobes/address/data
//     o_bus_rdata, o_bus_hit              combinational load data, decode hit
//     o_sig_valid/o_sig_data/o_sig_idx    signature stream, i_sig_ready sink
//     o_test_done/pass/timeout, o_fail_code  end-of-test status
module sim_host_if
    import sim_host_if_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
    parameter logic [31:0] SIG_BASE       = DEF_SIG_BASE,
    parameter int unsigned SIG_WORDS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 550
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_bus_we,
    input  logic                         i_bus_re,
    input  logic [31:0]                  i_bus_addr,
    input  logic [31:0]                  i_bus_wdata,
    input  logic [3:0]                   i_bus_wstrb,
    output logic [31:0]                  o_bus_rdata,
    output logic                         o_bus_hit,
    output logic                         o_sig_valid,
    input  logic                         i_sig_ready,
    output logic [31:0]                  o_sig_data,
    output logic [$clog2(SIG_WORDS)-1:0] o_sig_idx,
    output logic                         o_test_done,
    output logic                         o_test_pass,
    output logic                         o_test_timeout,
    output logic [30:0]                  o_fail_code
);

    localparam int unsigned IDX_W    = $clog2(SIG_WORDS);
    localparam logic [31:0] TOH_WORD = TOHOST_ADDR & 32'hFFFF_FFFC;
    localparam logic [31:0] CNT_WORD = (TOHOST_ADDR + 32'd4) & 32'hFFFF_FFFC;
    localparam logic [32:0] SIG_END  = {1'b0, SIG_BASE} + 33'(4 * SIG_WORDS);
    localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_cnt;
    logic [31:0]        r_tohost;
    logic [IDX_W-1:0]   r_hwm;
    logic               r_hwm_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               r_pass;
    logic               r_timeout;
    logic [30:0]        r_fail_code;

    logic [31:0]        w_word;
    logic               w_hit_tohost, w_hit_cnt, w_hit_sig;
    logic [IDX_W-1:0]   w_sig_idx;
    logic               w_run;
    logic               w_sig_wr, w_toh_wr;
    logic [31:0]        w_toh_new;
    logic               w_end_tohost, w_wd_expire, w_end;
    logic               w_hwm_valid_nxt;
    logic               w_hs, w_last;
    logic               w_start_dump;
    logic               w_rd_en;
    logic [IDX_W-1:0]   w_rd_addr;
    logic [31:0]        w_buf_rdata_a;
    logic [31:0]        w_buf_rdata_b;

    // ---------------- address decode ----------------
    assign w_word       = i_bus_addr & 32'hFFFF_FFFC;
    assign w_hit_tohost = (w_word == TOH_WORD);
    assign w_hit_cnt    = (w_word == CNT_WORD);
    assign w_hit_sig    = (w_word >= SIG_BASE) && ({1'b0, w_word} < SIG_END);
    assign w_sig_idx    = IDX_W'((w_word - SIG_BASE) >> 2);

    // ---------------- store acceptance and end conditions ----------------
    assign w_run           = (r_state == ST_RUN);
    assign w_sig_wr        = w_run && i_bus_we && w_hit_sig;
    assign w_toh_wr        = w_run && i_bus_we && w_hit_tohost;
    assign w_toh_new       = apply_wstrb(r_tohost, i_bus_wdata, i_bus_wstrb);
    assign w_end_tohost    = w_toh_wr && i_bus_wdata[0];
    assign w_wd_expire     = w_run && (r_cnt == WD_LAST);
    assign w_end           = w_end_tohost || w_wd_expire;
    assign w_hwm_valid_nxt = r_hwm_valid || w_sig_wr;

    assign w_hs   = (r_state == ST_DUMP) && i_sig_ready;
    assign w_last = (r_idx == r_hwm);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_dump = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_idx + IDX_W'(1);
        case (r_state)
            ST_RUN: begin
                if (w_end) begin
                    if (w_hwm_valid_nxt) begin
                        w_state_nxt  = ST_DUMP;
                        w_start_dump = 1'b1;
                        w_rd_en      = 1'b1;
                        w_rd_addr    = '0;
                    end else begin
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DUMP: begin
                if (w_hs) begin
                    if (w_last) w_state_nxt = ST_DONE;
                    else        w_rd_en     = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_tohost    <= '0;
            r_hwm       <= '0;
            r_hwm_valid <= 1'b0;
            r_idx       <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_code <= '0;
        end else begin
            if (w_run && (r_cnt != '1)) r_cnt <= r_cnt + 32'd1;

            if (w_toh_wr) r_tohost <= w_toh_new;

            if (w_sig_wr) begin
                if (!r_hwm_valid || (w_sig_idx > r_hwm)) r_hwm <= w_sig_idx;
                r_hwm_valid <= 1'b1;
            end

            // A tohost end in the expiry cycle takes priority over the timeout.
            if (w_end_tohost) begin
                r_pass      <= (w_toh_new == 32'd1);
                r_fail_code <= (w_toh_new == 32'd1) ? '0 : w_toh_new[31:1];
            end else if (w_wd_expire) begin
                r_timeout   <= 1'b1;
            end

            if (w_start_dump)          r_idx <= '0;
            else if (w_hs && !w_last)  r_idx <= r_idx + IDX_W'(1);
        end
    end

    // ---------------- signature buffer ----------------
    sim_host_if_sig_buf #(
        .SIG_WORDS (SIG_WORDS)
    ) u_sig_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (w_sig_wr),
        .i_waddr   (w_sig_idx),
        .i_wdata   (i_bus_wdata),
        .i_wstrb   (i_bus_wstrb),
        .i_raddr_a (w_sig_idx),
        .o_rdata_a (w_buf_rdata_a),
        .i_re_b    (w_rd_en),
        .i_raddr_b (w_rd_addr),
        .o_rdata_b (w_buf_rdata_b)
    );

    // ---------------- bus load path ----------------
    always_comb begin
        o_bus_rdata = '0;
        if (i_bus_re) begin
            if (w_hit_tohost)   o_bus_rdata = r_tohost;
            else if (w_hit_cnt) o_bus_rdata = r_cnt;
            else if (w_hit_sig) o_bus_rdata = w_buf_rdata_a;
        end
    end

    assign o_bus_hit      = (i_bus_we || i_bus_re) && (w_hit_tohost || w_hit_cnt || w_hit_sig);

    assign o_sig_valid    = (r_state == ST_DUMP);
    assign o_sig_data     = w_buf_rdata_b;
    assign o_sig_idx      = r_idx;
    assign o_test_done    = (r_state == ST_DONE);
    assign o_test_pass    = r_pass;
    assign o_test_timeout = r_timeout;
    assign o_fail_code    = r_fail_code;

endmodule

// File: tb/tb_sim_host_if.sv
// tb_sim_host_if
//   Directed bench for sim_host_if with a scoreboard: expected signature
//   words are queued as stimulus is issued and a negedge monitor compares
//   every presented word against the queue head.
module tb_sim_host_if;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] CNTA   = 32'h0000_1004;
    localparam logic [31:0] SIGB   = 32'h0000_2000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_bus_we, i_bus_re;
    logic [31:0] i_bus_addr, i_bus_wdata;
    logic [3:0]  i_bus_wstrb;
    logic [31:0] o_bus_rdata;
    logic        o_bus_hit;
    logic        o_sig_valid;
    logic        i_sig_ready;
    logic [31:0] o_sig_data;
    logic [5:0]  o_sig_idx;
    logic        o_test_done, o_test_pass, o_test_timeout;
    logic [30:0] o_fail_code;

    always #5 i_clk = ~i_clk;

    sim_host_if #(
        .TOHOST_ADDR    (TOHOST),
        .SIG_BASE       (SIGB),
        .SIG_WORDS      (64),
        .TIMEOUT_CYCLES (550)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_bus_we       (i_bus_we),
        .i_bus_re       (i_bus_re),
        .i_bus_addr     (i_bus_addr),
        .i_bus_wdata    (i_bus_wdata),
        .i_bus_wstrb    (i_bus_wstrb),
        .o_bus_rdata    (o_bus_rdata),
        .o_bus_hit      (o_bus_hit),
        .o_sig_valid    (o_sig_valid),
        .i_sig_ready    (i_sig_ready),
        .o_sig_data     (o_sig_data),
        .o_sig_idx      (o_sig_idx),
        .o_test_done    (o_test_done),
        .o_test_pass    (o_test_pass),
        .o_test_timeout (o_test_timeout),
        .o_fail_code    (o_fail_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [5:0] idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every presented word must match the queue head.
    always @(negedge i_clk) begin
        if (i_rst_n && o_sig_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sig_unexpected: got idx %0d data %h, required no word", o_sig_idx, o_sig_data);
            end else begin
                check("sig_idx", 32'(o_sig_idx), 32'(exp_q[0].idx));
                check("sig_data", o_sig_data, exp_q[0].data);
                if (i_sig_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        i_bus_we    = 1'b1;
        i_bus_addr  = a;
        i_bus_wdata = d;
        i_bus_wstrb = s;
        @(posedge i_clk);
        #1;
        i_bus_we    = 1'b0;
        i_bus_addr  = '0;
        i_bus_wdata = '0;
        i_bus_wstrb = '0;
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
        i_bus_re   = 1'b1;
        i_bus_addr = a;
        #1;
        check(name, o_bus_rdata, exp);
        check({name, "_hit"}, 32'(o_bus_hit), 32'(exp_hit));
        i_bus_re   = 1'b0;
        i_bus_addr = '0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #2;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (!o_test_done && i < 50) begin
            @(posedge i_clk);
            #1;
            i++;
        end
        check(name, 32'(o_test_done), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},   32'(o_sig_valid),    32'd0);
        check({tag, "_idx"},     32'(o_sig_idx),      32'd0);
        check({tag, "_data"},    o_sig_data,          32'd0);
        check({tag, "_done"},    32'(o_test_done),    32'd0);
        check({tag, "_pass"},    32'(o_test_pass),    32'd0);
        check({tag, "_timeout"}, 32'(o_test_timeout), 32'd0);
        check({tag, "_fcode"},   32'(o_fail_code),    32'd0);
        check({tag, "_rdata"},   o_bus_rdata,         32'd0);
        check({tag, "_hit"},     32'(o_bus_hit),      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        i_rst_n     = 1'b1;
        i_bus_we    = 1'b0;
        i_bus_re    = 1'b0;
        i_bus_addr  = '0;
        i_bus_wdata = '0;
        i_bus_wstrb = '0;
        i_sig_ready = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_zero("reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // 1. pass path
        i_sig_ready = 1'b1;
        store(SIGB,        32'hDEAD_BEEF, 4'hF);
        store(SIGB + 32'd4, 32'h1234_5678, 4'hF);
        push_exp(6'd0, 32'hDEAD_BEEF);
        push_exp(6'd1, 32'h1234_5678);
        store(TOHOST, 32'd1, 4'hF);
        check("t1_valid_first", 32'(o_sig_valid), 32'd1);
        wait_done("t1_done");
        check("t1_pass",  32'(o_test_pass),    32'd1);
        check("t1_fcode", 32'(o_fail_code),    32'd0);
        check("t1_tmo",   32'(o_test_timeout), 32'd0);
        check("t1_qempty", 32'(exp_q.size()),  32'd0);

        // 2. fail code, no signature
        do_reset();
        store(TOHOST, 32'd7, 4'hF);
        check("t2_done",  32'(o_test_done),    32'd1);
        check("t2_valid", 32'(o_sig_valid),    32'd0);
        check("t2_pass",  32'(o_test_pass),    32'd0);
        check("t2_fcode", 32'(o_fail_code),    32'd3);
        check("t2_tmo",   32'(o_test_timeout), 32'd0);

        // 3. byte strobes and backpressure
        do_reset();
        i_sig_ready = 1'b1;
        store(SIGB + 32'd8, 32'hFFFF_FFFF, 4'hF);
        store(SIGB + 32'd8, 32'h0000_AB00, 4'b0010);
        load("t3_word2", SIGB + 32'd8, 32'hFFFF_ABFF, 1'b1);
        load("t3_miss", 32'h0000_3000, 32'd0, 1'b0);
        push_exp(6'd0, 32'hDEAD_BEEF);
        push_exp(6'd1, 32'h1234_5678);
        push_exp(6'd2, 32'hFFFF_ABFF);
        store(TOHOST, 32'd1, 4'hF);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_sig_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_valid", 32'(o_sig_valid), 32'd1);
            check("t3_stall_idx",   32'(o_sig_idx),   32'd2);
            check("t3_stall_data",  o_sig_data,       32'hFFFF_ABFF);
            @(posedge i_clk);
            #1;
        end
        i_sig_ready = 1'b1;
        wait_done("t3_done");
        check("t3_pass",   32'(o_test_pass),   32'd1);
        check("t3_qempty", 32'(exp_q.size()),  32'd0);

        // 4a. watchdog expiry
        do_reset();
        repeat (549) @(posedge i_clk);
        #1;
        load("t4_cnt549", CNTA, 32'd549, 1'b1);
        check("t4_tmo_before",  32'(o_test_timeout), 32'd0);
        check("t4_done_before", 32'(o_test_done),    32'd0);
        @(posedge i_clk);
        #1;
        check("t4_tmo",   32'(o_test_timeout), 32'd1);
        check("t4_done",  32'(o_test_done),    32'd1);
        check("t4_pass",  32'(o_test_pass),    32'd0);
        check("t4_fcode", 32'(o_fail_code),    32'd0);
        load("t4_cnt_frozen", CNTA, 32'd550, 1'b1);

        // 4b. tohost end in the expiry cycle wins
        do_reset();
        repeat (549) @(posedge i_clk);
        #1;
        load("t4b_cnt549", CNTA, 32'd549, 1'b1);
        store(TOHOST, 32'd1, 4'hF);
        check("t4b_tmo",  32'(o_test_timeout), 32'd0);
        check("t4b_done", 32'(o_test_done),    32'd1);
        check("t4b_pass", 32'(o_test_pass),    32'd1);

        // 5. post-end isolation
        store(SIGB,   32'h5555_5555, 4'hF);
        store(TOHOST, 32'h0000_0009, 4'hF);
        check("t5_done",  32'(o_test_done),    32'd1);
        check("t5_pass",  32'(o_test_pass),    32'd1);
        check("t5_tmo",   32'(o_test_timeout), 32'd0);
        check("t5_fcode", 32'(o_fail_code),    32'd0);
        check("t5_valid", 32'(o_sig_valid),    32'd0);
        load("t5_sig0",   SIGB,   32'hDEAD_BEEF, 1'b1);
        load("t5_tohost", TOHOST, 32'd1,         1'b1);
        load("t5_cnt",    CNTA,   32'd550,       1'b1);

        // 6. reset mid-dump
        do_reset();
        i_sig_ready = 1'b1;
        store(SIGB,         32'h1111_1111, 4'hF);
        store(SIGB + 32'd4, 32'h2222_2222, 4'hF);
        store(SIGB + 32'd8, 32'h3333_3333, 4'hF);
        push_exp(6'd0, 32'h1111_1111);
        push_exp(6'd1, 32'h2222_2222);
        push_exp(6'd2, 32'h3333_3333);
        store(TOHOST, 32'd1, 4'hF);
        @(posedge i_clk);
        #1;
        check("t6_idx1",  32'(o_sig_idx), 32'd1);
        check("t6_data1", o_sig_data,     32'h2222_2222);
        i_rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        exp_q.delete();
        #2;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        load("t6_cnt0", CNTA, 32'd0, 1'b1);
        check("t6_run_done", 32'(o_test_done), 32'd0);
        load("t6_ram_kept", SIGB + 32'd8, 32'h3333_3333, 1'b1);
        store(TOHOST, 32'd1, 4'hF);
        check("t6_clean_done",  32'(o_test_done), 32'd1);
        check("t6_clean_valid", 32'(o_sig_valid), 32'd0);
        check("t6_clean_pass",  32'(o_test_pass), 32'd1);

        repeat (2) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
